// File: rtl/regfile_writeback.sv
// regfile_writeback -- writeback stage feeding the register file write port.
//
// Collects results from NSRC execution units over valid/ready, buffers them in a
// FIFO_DEPTH-entry write buffer and drains one write per cycle into the regfile.
// A 2-bit pending counter per architectural register lets decode detect RAW
// hazards. All traffic is held off until the regfile's post-reset clear window
// (INIT_CYCLES cycles) has elapsed.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   src_valid/src_ready       per-source handshake (src_ready is combinational)
//   src_rd, src_data          per-source destination register and result data
//   claim_valid/claim_ready   decode reserving a destination register
//   claim_rd                  register being reserved
//   chk_rs1/chk_rs2           decode source registers to check
//   rs1_busy/rs2_busy         checked register has an uncommitted write pending
//   init_done                 clear window elapsed
//   wr_en, wr_rd, wr_data     regfile write port (rd/data forced to 0 when idle)
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   Adds byp1_hit/byp2_hit and byp1_data/byp2_data, flagging that the write on
//   the port this cycle targets a checked source register, and suppresses the
//   busy flag when that write is the last one pending for the register.

module regfile_writeback #(
    parameter int NSRC        = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int INIT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC-1:0]      src_valid,
    output logic [NSRC-1:0]      src_ready,
    input  logic [5*NSRC-1:0]    src_rd,
    input  logic [32*NSRC-1:0]   src_data,
    input  logic                 claim_valid,
    input  logic [4:0]           claim_rd,
    output logic                 claim_ready,
    input  logic [4:0]           chk_rs1,
    input  logic [4:0]           chk_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 init_done,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                 byp1_hit,
    output logic                 byp2_hit,
    output logic [31:0]          byp1_data,
    output logic [31:0]          byp2_data,
`endif
    output logic                 wr_en,
    output logic [4:0]           wr_rd,
    output logic [31:0]          wr_data
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    logic [IW-1:0] init_cnt_r;
    logic          init_done_s;

    logic [4:0]    fifo_rd_r   [FIFO_DEPTH];
    logic [31:0]   fifo_data_r [FIFO_DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rr_ptr_r;

    logic          pop_s;
    logic [4:0]    wr_rd_s;
    logic [31:0]   wr_data_s;

    logic [CW-1:0] free_s;
    logic [CW-1:0] push_num_s;
    logic [NSRC-1:0] grant_s;
    logic [NSRC-1:0] push_en_s;
    logic [AW-1:0] push_off_s [NSRC];
    logic [PW-1:0] ptr_nxt_s;

    logic [1:0]    sb_cnt_r [32];
    logic          claim_ready_s;
    logic          inc_s;
    logic [1:0]    rs1_cnt_s;
    logic [1:0]    rs2_cnt_s;

    // Clear-window counter: saturates at INIT_CYCLES, which is the init_done state.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_r <= '0;
        end else if (init_cnt_r != INIT_LAST) begin
            init_cnt_r <= init_cnt_r + 1'b1;
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end

    // Drain side: head of the buffer is presented whenever the buffer is non-empty.
    always_comb begin
        init_done_s = (init_cnt_r == INIT_LAST);
        pop_s       = (count_r != {CW{1'b0}}) && init_done_s;
        if (pop_s) begin
            wr_rd_s   = fifo_rd_r[head_r];
            wr_data_s = fifo_data_r[head_r];
        end else begin
            wr_rd_s   = 5'd0;
            wr_data_s = 32'd0;
        end
    end

    // Round-robin grant from rr_ptr_r, limited by free slots (a pop this cycle
    // frees one). Writes to x0 are granted but take no slot and are never pushed.
    always_comb begin
        int idx;
        grant_s    = '0;
        push_en_s  = '0;
        push_num_s = '0;
        ptr_nxt_s  = rr_ptr_r;
        for (int i = 0; i < NSRC; i++) begin
            push_off_s[i] = '0;
        end
        free_s = DEPTH_C - count_r + {{(CW-1){1'b0}}, pop_s};
        idx    = int'(rr_ptr_r);
        for (int k = 0; k < NSRC; k++) begin
            if (init_done_s && src_valid[idx] && (push_num_s < free_s)) begin
                grant_s[idx] = 1'b1;
                ptr_nxt_s    = (idx == NSRC - 1) ? '0 : PW'(idx + 1);
                if (src_rd[5*idx +: 5] != 5'd0) begin
                    push_en_s[idx]  = 1'b1;
                    push_off_s[idx] = push_num_s[AW-1:0];
                    push_num_s      = push_num_s + 1'b1;
                end else begin
                    push_en_s[idx]  = 1'b0;
                end
            end else begin
                grant_s[idx] = 1'b0;
            end
            idx = (idx == NSRC - 1) ? 0 : idx + 1;
        end
    end

    // Buffer pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r   <= '0;
            tail_r   <= '0;
            count_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            tail_r   <= tail_r + push_num_s[AW-1:0];
            head_r   <= pop_s ? head_r + 1'b1 : head_r;
            count_r  <= count_r + push_num_s - {{(CW-1){1'b0}}, pop_s};
            rr_ptr_r <= ptr_nxt_s;
        end
    end

    // Buffer storage: granted entries land at consecutive slots in grant order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push_en_s[i]) begin
                fifo_rd_r[tail_r + push_off_s[i]]   <= src_rd[5*i +: 5];
                fifo_data_r[tail_r + push_off_s[i]] <= src_data[32*i +: 32];
            end
        end
    end

    // Claim acceptance: a counter at 3 cannot take another reservation.
    always_comb begin
        if (claim_rd == 5'd0) begin
            claim_ready_s = init_done_s;
        end else begin
            claim_ready_s = init_done_s && (sb_cnt_r[claim_rd] != 2'd3);
        end
        inc_s = claim_valid && claim_ready_s && (claim_rd != 5'd0);
    end

    // Pending scoreboard: claim increments, commit decrements, both together cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                sb_cnt_r[r] <= 2'd0;
            end
        end else begin
            sb_cnt_r[0] <= 2'd0;
            for (int r = 1; r < 32; r++) begin
                if (inc_s && (claim_rd == 5'(r)) && !(pop_s && (wr_rd_s == 5'(r)))) begin
                    if (sb_cnt_r[r] != 2'd3) begin
                        sb_cnt_r[r] <= sb_cnt_r[r] + 2'd1;
                    end
                end else if (pop_s && (wr_rd_s == 5'(r)) && !(inc_s && (claim_rd == 5'(r)))) begin
                    if (sb_cnt_r[r] != 2'd0) begin
                        sb_cnt_r[r] <= sb_cnt_r[r] - 2'd1;
                    end
                end
            end
        end
    end

    // Hazard flags for decode, with optional bypass from the write port.
    always_comb begin
        rs1_cnt_s = sb_cnt_r[chk_rs1];
        rs2_cnt_s = sb_cnt_r[chk_rs2];
`ifdef REGFILE_WB_BYPASS_EN
        byp1_hit  = pop_s && (wr_rd_s == chk_rs1) && (chk_rs1 != 5'd0);
        byp2_hit  = pop_s && (wr_rd_s == chk_rs2) && (chk_rs2 != 5'd0);
        byp1_data = wr_data_s;
        byp2_data = wr_data_s;
        rs1_busy  = (rs1_cnt_s != 2'd0) && !(byp1_hit && (rs1_cnt_s == 2'd1));
        rs2_busy  = (rs2_cnt_s != 2'd0) && !(byp2_hit && (rs2_cnt_s == 2'd1));
`else
        rs1_busy  = (rs1_cnt_s != 2'd0);
        rs2_busy  = (rs2_cnt_s != 2'd0);
`endif
    end

    // Output assignments.
    always_comb begin
        src_ready   = grant_s;
        claim_ready = claim_ready_s;
        init_done   = init_done_s;
        wr_en       = pop_s;
        wr_rd       = wr_rd_s;
        wr_data     = wr_data_s;
    end

endmodule
